w3d_mmio_regs: RTL and testbench
================================

// Module: w3d_mmio_regs
// PURPOSE
//  AXI-Lite responder at the far end of the platform's external MMIO port (the simplified mmio_* channel set:
//  no strobes, no resp, no ids). Terminates host loads/stores with a small control register bank:
//  ID, scratch, 64-bit cycle counter, GPIO, and masked interrupt aggregation. Base address decode is done upstream.
// PARAMETERS
//  ID_VALUE   32'h5733_4400  constant returned by the ID register
//  GPIO_W     8              width of gpio_out / gpio_in (1..32)
//  IRQ_W      4              number of interrupt sources (1..32)
// PORTS
//  clk           in   1       sole clock
//  srst          in   1       reset, synchronous, active-high
//  mmio_awvalid  in   1       write address valid
//  mmio_awready  out  1       write address ready
//  mmio_awaddr   in   32      write byte address; only [4:2] decoded
//  mmio_wvalid   in   1       write data valid
//  mmio_wready   out  1       write data ready
//  mmio_wdata    in   32      write data (full word, no strobes)
//  mmio_bvalid   out  1       write response valid
//  mmio_bready   in   1       write response ready
//  mmio_arvalid  in   1       read address valid
//  mmio_arready  out  1       read address ready
//  mmio_araddr   in   32      read byte address; only [4:2] decoded
//  mmio_rvalid   out  1       read data valid
//  mmio_rready   in   1       read data ready
//  mmio_rdata    out  32      read data
//  gpio_in       in   GPIO_W  sampled inputs (same clock domain)
//  gpio_out      out  GPIO_W  GPIO_OUT register contents
//  irq_src       in   IRQ_W   level/pulse interrupt sources, sampled every cycle
//  irq           out  1       |(IRQ_PEND & IRQ_MASK), registered
// BEHAVIOUR
//  Reset (srst=1 at edge): all outputs 0; awready/wready/arready 0 during reset, 1 the cycle after; SCRATCH,
//   GPIO_OUT, IRQ_PEND, IRQ_MASK, counter, CYC_HI shadow, AW/W holding regs all 0. Reset mid-transaction
//   drops it silently (no bvalid/rvalid after reset).
//  Map (awaddr/araddr[4:2]): 0 ID RO | 1 SCRATCH RW | 2 CYC_LO RO | 3 CYC_HI RO (shadow) | 4 GPIO_OUT RW
//   | 5 GPIO_IN RO (zero-extended) | 6 IRQ_PEND W1C | 7 IRQ_MASK RW (IRQ_W bits). Bits [31:5],[1:0] ignored (aliasing).
//   Writes to RO regs complete normally with no effect; unused upper bits read 0.
//  Write path: AW and W accepted independently into one holding slot each.
//   awready = !aw_held & !bvalid; wready = !w_held & !bvalid.
//   Commit fires when (aw_held|aw_hs) & (w_held|w_hs) & !bvalid: register updated at that edge, holding slots
//   cleared, bvalid=1 next cycle. AW+W in same cycle t -> bvalid at t+1. bvalid held until bready; clears on hs.
//   Only one write outstanding; no new AW/W accepted while bvalid=1.
//  Read path: arready = !rvalid. Handshake at t -> rdata/rvalid registered at t+1; rdata stable until rready hs.
//   Read samples pre-edge state: read and commit of same reg in same cycle returns OLD value.
//  Read/write fully independent; both may hand-shake in the same cycle.
//  Counter: 64-bit, +1 every cycle, wraps 2^64-1 -> 0. Reading CYC_LO returns counter[31:0] and copies
//   counter[63:32] (same cycle's value) into CYC_HI shadow; CYC_HI returns shadow (coherent lo-then-hi read).
//  IRQ: pend_next = (pend & ~clr) | irq_src, clr = wdata[IRQ_W-1:0] on IRQ_PEND commit; set wins over clear.
//   irq = registered |(pend & mask), i.e. one cycle after pend/mask update.
// STRUCTURE
//  Package w3d_mmio_pkg: enum of register word indices (REG_ID..REG_IRQ_MASK), REG_IDX_W=3, ID default constant.
//  One natural sub-module: w3d_axil_resp_fe (AW/W holding + B/AR/R handshake, exposes wr_en/wr_idx/wr_data,
//   rd_en/rd_idx, rd_data in); register bank and counter stay in this module.
// TESTING
//  Reset then read 0x00 -> rdata=32'h5733_4400 at cycle after AR hs; rvalid held 5 cycles with rready=0, data stable.
//  AW at t, W at t+3 -> commit at t+3, bvalid at t+4; awready=0 t+1..bvalid hs; SCRATCH then reads written value.
//  AW+W same cycle writing 0xA5A5_A5A5 to SCRATCH with AR to SCRATCH same cycle -> rdata=old value (0).
//  Preload counter near 32'hFFFF_FFFF low wrap: read CYC_LO then CYC_HI -> hi equals value latched at lo read.
//  irq_src[2] pulse, MASK=4 -> irq=1 one cycle after PEND set; write PEND=4 while irq_src[2]=1 -> bit stays set.
//  Write 0x1234 to ID and addr 0x20 (alias of ID) -> bvalid completes, ID unchanged; srst mid-bvalid -> bvalid=0 next.

Source files
------------

// File: rtl/w3d_mmio_pkg.sv
// rtl/w3d_mmio_pkg.sv - shared register map definitions for the MMIO register block
package w3d_mmio_pkg;

    localparam int          REG_IDX_W  = 3;
    localparam logic [31:0] ID_DEFAULT = 32'h5733_4400;

    // Word index of each register, taken from address bits [4:2].
    typedef enum logic [REG_IDX_W-1:0] {
        REG_ID       = 3'd0,
        REG_SCRATCH  = 3'd1,
        REG_CYC_LO   = 3'd2,
        REG_CYC_HI   = 3'd3,
        REG_GPIO_OUT = 3'd4,
        REG_GPIO_IN  = 3'd5,
        REG_IRQ_PEND = 3'd6,
        REG_IRQ_MASK = 3'd7
    } reg_idx_e;

    // Only [4:2] select a register; everything else aliases.
    function automatic logic [REG_IDX_W-1:0] addr_to_idx(input logic [31:0] addr);
        return addr[4:2];
    endfunction

endpackage

// File: rtl/w3d_axil_resp_fe.sv
// rtl/w3d_axil_resp_fe.sv - AXI-Lite responder front end: AW/W holding, B/AR/R handshakes
//
// Ports:
//   clk, srst                   clock, synchronous active-high reset
//   i_awvalid/o_awready/i_awaddr write address channel
//   i_wvalid/o_wready/i_wdata    write data channel
//   o_bvalid/i_bready            write response channel
//   i_arvalid/o_arready/i_araddr read address channel
//   o_rvalid/i_rready/o_rdata    read data channel
//   o_wr_en/o_wr_idx/o_wr_data   single-cycle register write commit
//   o_rd_en/o_rd_idx/i_rd_data   read request and the bank's combinational read data
module w3d_axil_resp_fe
    import w3d_mmio_pkg::*;
(
    input  logic                 clk,
    input  logic                 srst,
    input  logic                 i_awvalid,
    output logic                 o_awready,
    input  logic [31:0]          i_awaddr,
    input  logic                 i_wvalid,
    output logic                 o_wready,
    input  logic [31:0]          i_wdata,
    output logic                 o_bvalid,
    input  logic                 i_bready,
    input  logic                 i_arvalid,
    output logic                 o_arready,
    input  logic [31:0]          i_araddr,
    output logic                 o_rvalid,
    input  logic                 i_rready,
    output logic [31:0]          o_rdata,
    output logic                 o_wr_en,
    output logic [REG_IDX_W-1:0] o_wr_idx,
    output logic [31:0]          o_wr_data,
    output logic                 o_rd_en,
    output logic [REG_IDX_W-1:0] o_rd_idx,
    input  logic [31:0]          i_rd_data
);

    // r_live keeps every ready low for the cycle in which reset is applied.
    logic                 r_live;
    logic                 r_aw_held;
    logic                 r_w_held;
    logic [REG_IDX_W-1:0] r_aw_idx;
    logic [31:0]          r_wdata;
    logic                 r_bvalid;
    logic                 r_rvalid;
    logic [31:0]          r_rdata;

    logic w_aw_hs;
    logic w_w_hs;
    logic w_ar_hs;
    logic w_commit;
    logic w_unused_addr;

    assign o_awready = r_live & ~r_aw_held & ~r_bvalid;
    assign o_wready  = r_live & ~r_w_held & ~r_bvalid;
    assign o_arready = r_live & ~r_rvalid;

    assign w_aw_hs  = i_awvalid & o_awready;
    assign w_w_hs   = i_wvalid & o_wready;
    assign w_ar_hs  = i_arvalid & o_arready;

    // A write commits as soon as both halves are present, whether held or arriving now.
    assign w_commit = (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs) & ~r_bvalid;

    assign o_wr_en   = w_commit;
    assign o_wr_idx  = r_aw_held ? r_aw_idx : addr_to_idx(i_awaddr);
    assign o_wr_data = r_w_held ? r_wdata : i_wdata;

    assign o_rd_en   = w_ar_hs;
    assign o_rd_idx  = addr_to_idx(i_araddr);

    assign o_bvalid  = r_bvalid;
    assign o_rvalid  = r_rvalid;
    assign o_rdata   = r_rdata;

    assign w_unused_addr = ^{i_awaddr[31:5], i_awaddr[1:0], i_araddr[31:5], i_araddr[1:0]};

    always_ff @(posedge clk) begin
        if (srst) begin
            r_live    <= 1'b0;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_aw_idx  <= '0;
            r_wdata   <= '0;
            r_bvalid  <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_live <= 1'b1;

            if (w_commit) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
            end else begin
                if (w_aw_hs) begin
                    r_aw_held <= 1'b1;
                    r_aw_idx  <= addr_to_idx(i_awaddr);
                end
                if (w_w_hs) begin
                    r_w_held <= 1'b1;
                    r_wdata  <= i_wdata;
                end
            end

            if (w_commit) begin
                r_bvalid <= 1'b1;
            end else if (i_bready) begin
                r_bvalid <= 1'b0;
            end

            if (w_ar_hs) begin
                r_rvalid <= 1'b1;
                r_rdata  <= i_rd_data;
            end else if (i_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/w3d_mmio_regs.sv
// rtl/w3d_mmio_regs.sv - MMIO control register bank: ID, scratch, cycle counter, GPIO, IRQ
//
// Ports:
//   clk, srst      clock, synchronous active-high reset
//   mmio_*         simplified AXI-Lite responder channels (no strobes, no resp, no ids)
//   gpio_in        GPIO inputs, read through GPIO_IN
//   gpio_out       GPIO_OUT register contents
//   irq_src        interrupt sources, OR-ed into IRQ_PEND every cycle
//   irq            registered OR of pending & mask
module w3d_mmio_regs
    import w3d_mmio_pkg::*;
#(
    parameter logic [31:0] ID_VALUE  = ID_DEFAULT,
    parameter int          GPIO_W    = 8,
    parameter int          IRQ_W     = 4,
    // Value the cycle counter takes at reset.
    parameter logic [63:0] CYC_RESET = 64'd0
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              mmio_awvalid,
    output logic              mmio_awready,
    input  logic [31:0]       mmio_awaddr,
    input  logic              mmio_wvalid,
    output logic              mmio_wready,
    input  logic [31:0]       mmio_wdata,
    output logic              mmio_bvalid,
    input  logic              mmio_bready,
    input  logic              mmio_arvalid,
    output logic              mmio_arready,
    input  logic [31:0]       mmio_araddr,
    output logic              mmio_rvalid,
    input  logic              mmio_rready,
    output logic [31:0]       mmio_rdata,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    input  logic [IRQ_W-1:0]  irq_src,
    output logic              irq
);

    logic                 w_wr_en;
    logic [REG_IDX_W-1:0] w_wr_idx;
    logic [31:0]          w_wr_data;
    logic                 w_rd_en;
    logic [REG_IDX_W-1:0] w_rd_idx;
    logic [31:0]          w_rd_data;

    logic [63:0]       r_cyc;
    logic [31:0]       r_cyc_hi_shadow;
    logic [31:0]       r_scratch;
    logic [GPIO_W-1:0] r_gpio_out;
    logic [IRQ_W-1:0]  r_pend;
    logic [IRQ_W-1:0]  r_mask;
    logic              r_irq;

    logic              w_wr_scratch;
    logic              w_wr_gpio;
    logic              w_wr_pend;
    logic              w_wr_mask;
    logic              w_rd_cyc_lo;
    logic [IRQ_W-1:0]  w_pend_clr;

    w3d_axil_resp_fe u_fe (
        .clk       (clk),
        .srst      (srst),
        .i_awvalid (mmio_awvalid),
        .o_awready (mmio_awready),
        .i_awaddr  (mmio_awaddr),
        .i_wvalid  (mmio_wvalid),
        .o_wready  (mmio_wready),
        .i_wdata   (mmio_wdata),
        .o_bvalid  (mmio_bvalid),
        .i_bready  (mmio_bready),
        .i_arvalid (mmio_arvalid),
        .o_arready (mmio_arready),
        .i_araddr  (mmio_araddr),
        .o_rvalid  (mmio_rvalid),
        .i_rready  (mmio_rready),
        .o_rdata   (mmio_rdata),
        .o_wr_en   (w_wr_en),
        .o_wr_idx  (w_wr_idx),
        .o_wr_data (w_wr_data),
        .o_rd_en   (w_rd_en),
        .o_rd_idx  (w_rd_idx),
        .i_rd_data (w_rd_data)
    );

    assign w_wr_scratch = w_wr_en && (w_wr_idx == REG_SCRATCH);
    assign w_wr_gpio    = w_wr_en && (w_wr_idx == REG_GPIO_OUT);
    assign w_wr_pend    = w_wr_en && (w_wr_idx == REG_IRQ_PEND);
    assign w_wr_mask    = w_wr_en && (w_wr_idx == REG_IRQ_MASK);
    assign w_rd_cyc_lo  = w_rd_en && (w_rd_idx == REG_CYC_LO);
    assign w_pend_clr   = w_wr_pend ? w_wr_data[IRQ_W-1:0] : '0;

    // Read data reflects pre-edge state; a same-cycle commit is seen only by later reads.
    always_comb begin
        w_rd_data = '0;
        case (w_rd_idx)
            REG_ID:       w_rd_data = ID_VALUE;
            REG_SCRATCH:  w_rd_data = r_scratch;
            REG_CYC_LO:   w_rd_data = r_cyc[31:0];
            REG_CYC_HI:   w_rd_data = r_cyc_hi_shadow;
            REG_GPIO_OUT: w_rd_data[GPIO_W-1:0] = r_gpio_out;
            REG_GPIO_IN:  w_rd_data[GPIO_W-1:0] = gpio_in;
            REG_IRQ_PEND: w_rd_data[IRQ_W-1:0] = r_pend;
            REG_IRQ_MASK: w_rd_data[IRQ_W-1:0] = r_mask;
            default:      w_rd_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_cyc           <= CYC_RESET;
            r_cyc_hi_shadow <= '0;
            r_scratch       <= '0;
            r_gpio_out      <= '0;
            r_pend          <= '0;
            r_mask          <= '0;
            r_irq           <= 1'b0;
        end else begin
            r_cyc <= r_cyc + 64'd1;

            // Latch the upper half alongside a CYC_LO read so a following CYC_HI read is coherent.
            if (w_rd_cyc_lo) begin
                r_cyc_hi_shadow <= r_cyc[63:32];
            end
            if (w_wr_scratch) begin
                r_scratch <= w_wr_data;
            end
            if (w_wr_gpio) begin
                r_gpio_out <= w_wr_data[GPIO_W-1:0];
            end
            if (w_wr_mask) begin
                r_mask <= w_wr_data[IRQ_W-1:0];
            end

            // A source still asserted wins over a write-one-to-clear of the same bit.
            r_pend <= (r_pend & ~w_pend_clr) | irq_src;
            r_irq  <= |(r_pend & r_mask);
        end
    end

    assign gpio_out = r_gpio_out;
    assign irq      = r_irq;

endmodule

// File: tb/tb_w3d_mmio_regs.sv
// tb/tb_w3d_mmio_regs.sv - self-checking bench for w3d_mmio_regs
module tb_w3d_mmio_regs;

    localparam logic [31:0] ID_VAL   = 32'h5733_4400;
    localparam logic [63:0] CYC_INIT = 64'h0000_0001_FFFF_FFE0;

    logic        clk = 1'b0;
    logic        srst;
    logic        mmio_awvalid, mmio_awready;
    logic [31:0] mmio_awaddr;
    logic        mmio_wvalid, mmio_wready;
    logic [31:0] mmio_wdata;
    logic        mmio_bvalid, mmio_bready;
    logic        mmio_arvalid, mmio_arready;
    logic [31:0] mmio_araddr;
    logic        mmio_rvalid, mmio_rready;
    logic [31:0] mmio_rdata;
    logic [7:0]  gpio_in, gpio_out;
    logic [3:0]  irq_src;
    logic        irq;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [63:0] m_cyc;
    logic [31:0] m_shadow, m_scratch;
    logic [7:0]  m_gpio;
    logic [3:0]  m_pend, m_mask;

    w3d_mmio_regs #(
        .ID_VALUE  (ID_VAL),
        .GPIO_W    (8),
        .IRQ_W     (4),
        .CYC_RESET (CYC_INIT)
    ) dut (
        .clk          (clk),
        .srst         (srst),
        .mmio_awvalid (mmio_awvalid),
        .mmio_awready (mmio_awready),
        .mmio_awaddr  (mmio_awaddr),
        .mmio_wvalid  (mmio_wvalid),
        .mmio_wready  (mmio_wready),
        .mmio_wdata   (mmio_wdata),
        .mmio_bvalid  (mmio_bvalid),
        .mmio_bready  (mmio_bready),
        .mmio_arvalid (mmio_arvalid),
        .mmio_arready (mmio_arready),
        .mmio_araddr  (mmio_araddr),
        .mmio_rvalid  (mmio_rvalid),
        .mmio_rready  (mmio_rready),
        .mmio_rdata   (mmio_rdata),
        .gpio_in      (gpio_in),
        .gpio_out     (gpio_out),
        .irq_src      (irq_src),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    // Free-running cycle count: reset value while srst, otherwise +1 per clock.
    always @(posedge clk) begin
        if (srst) m_cyc <= CYC_INIT;
        else      m_cyc <= m_cyc + 64'd1;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_shadow = '0; m_scratch = '0; m_gpio = '0; m_pend = '0; m_mask = '0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int aw_dly, input int w_dly);
        bit aw_done, w_done, hs_aw, hs_w;
        int t, lat;
        aw_done = 0; w_done = 0; t = 0;
        while (!(aw_done && w_done) && t < 40) begin
            mmio_awvalid = !aw_done && (t >= aw_dly);
            mmio_awaddr  = a;
            mmio_wvalid  = !w_done && (t >= w_dly);
            mmio_wdata   = d;
            hs_aw = mmio_awvalid && mmio_awready;
            hs_w  = mmio_wvalid && mmio_wready;
            @(negedge clk);
            t++;
            if (hs_aw) aw_done = 1;
            if (hs_w)  w_done = 1;
        end
        mmio_awvalid = 0;
        mmio_wvalid  = 0;
        chk("wr_accept", {62'd0, aw_done, w_done}, 64'd3);
        chk("wr_bvalid_next", mmio_bvalid, 1);
        mmio_bready = 1;
        lat = 0;
        while (!mmio_bvalid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        @(negedge clk);
        mmio_bready = 0;
        chk("wr_bvalid_clear", mmio_bvalid, 0);
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [63:0] cyc);
        int g;
        g = 0;
        mmio_arvalid = 1;
        mmio_araddr  = a;
        while (!mmio_arready && g < 20) begin
            @(negedge clk);
            g++;
        end
        cyc = m_cyc;
        chk("rd_arready", mmio_arready, 1);
        @(negedge clk);
        mmio_arvalid = 0;
        chk("rd_rvalid", mmio_rvalid, 1);
        d = mmio_rdata;
        mmio_rready = 1;
        @(negedge clk);
        mmio_rready = 0;
    endtask

    initial begin
        logic [31:0] rd, d, a, exp;
        logic [63:0] cyc;
        int idx;

        srst = 1;
        mmio_awvalid = 0; mmio_awaddr = 0; mmio_wvalid = 0; mmio_wdata = 0; mmio_bready = 0;
        mmio_arvalid = 0; mmio_araddr = 0; mmio_rready = 0;
        gpio_in = 8'h00; irq_src = 4'h0;
        model_reset();
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_awready", mmio_awready, 0);
        chk("rst_wready", mmio_wready, 0);
        chk("rst_arready", mmio_arready, 0);
        chk("rst_bvalid", mmio_bvalid, 0);
        chk("rst_rvalid", mmio_rvalid, 0);
        chk("rst_rdata", mmio_rdata, 0);
        chk("rst_gpio_out", gpio_out, 0);
        chk("rst_irq", irq, 0);
        srst = 0;
        @(negedge clk);
        chk("post_rst_awready", mmio_awready, 1);
        chk("post_rst_wready", mmio_wready, 1);
        chk("post_rst_arready", mmio_arready, 1);

        // ID read with rready held low for 5 cycles
        mmio_arvalid = 1; mmio_araddr = 32'h0;
        @(negedge clk);
        mmio_arvalid = 0;
        for (int i = 0; i < 5; i++) begin
            chk("id_rvalid_hold", mmio_rvalid, 1);
            chk("id_rdata", mmio_rdata, ID_VAL);
            chk("id_arready_blocked", mmio_arready, 0);
            @(negedge clk);
        end
        mmio_rready = 1;
        @(negedge clk);
        mmio_rready = 0;
        chk("id_rvalid_clear", mmio_rvalid, 0);

        // AW at t, W at t+3
        d = $urandom;
        mmio_awvalid = 1; mmio_awaddr = 32'h4;
        chk("split_awready_t", mmio_awready, 1);
        @(negedge clk);
        mmio_awvalid = 0;
        for (int k = 1; k <= 3; k++) begin
            chk("split_awready_held", mmio_awready, 0);
            chk("split_bvalid_early", mmio_bvalid, 0);
            if (k == 3) begin
                mmio_wvalid = 1; mmio_wdata = d;
                chk("split_wready", mmio_wready, 1);
            end
            @(negedge clk);
        end
        mmio_wvalid = 0;
        chk("split_bvalid", mmio_bvalid, 1);
        chk("split_awready_bvalid", mmio_awready, 0);
        chk("split_wready_bvalid", mmio_wready, 0);
        mmio_bready = 1;
        @(negedge clk);
        mmio_bready = 0;
        chk("split_bvalid_clear", mmio_bvalid, 0);
        chk("split_awready_back", mmio_awready, 1);
        m_scratch = d;
        do_read(32'h4, rd, cyc);
        chk("split_scratch", rd, m_scratch);

        // Same-cycle AW+W+AR to SCRATCH returns the old value
        mmio_awvalid = 1; mmio_awaddr = 32'h4; mmio_wvalid = 1; mmio_wdata = 32'hA5A5_A5A5;
        mmio_arvalid = 1; mmio_araddr = 32'h4;
        @(negedge clk);
        mmio_awvalid = 0; mmio_wvalid = 0; mmio_arvalid = 0;
        chk("same_bvalid", mmio_bvalid, 1);
        chk("same_rvalid", mmio_rvalid, 1);
        chk("same_rdata_old", mmio_rdata, m_scratch);
        mmio_bready = 1; mmio_rready = 1;
        @(negedge clk);
        mmio_bready = 0; mmio_rready = 0;
        m_scratch = 32'hA5A5_A5A5;
        do_read(32'h4, rd, cyc);
        chk("same_scratch_new", rd, m_scratch);

        // Interrupt: pulse source 2 with mask 4
        do_write(32'h1C, 32'h4, 0, 0);
        m_mask = 4'h4;
        irq_src = 4'h4;
        @(negedge clk);
        irq_src = 4'h0;
        chk("irq_lag", irq, 0);
        @(negedge clk);
        chk("irq_set", irq, 1);
        m_pend = 4'h4;
        do_read(32'h18, rd, cyc);
        chk("irq_pend_read", rd, {28'd0, m_pend});
        irq_src = 4'h4;
        do_write(32'h18, 32'h4, 0, 0);
        do_read(32'h18, rd, cyc);
        chk("irq_set_wins", rd, 32'h4);
        chk("irq_still_set", irq, 1);
        irq_src = 4'h0;
        do_write(32'h18, 32'h4, 1, 0);
        m_pend = 4'h0;
        do_read(32'h18, rd, cyc);
        chk("irq_pend_cleared", rd, {28'd0, m_pend});
        chk("irq_cleared", irq, 0);

        // Writes to RO registers, including an aliased address
        do_write(32'h0, 32'h1234, 0, 2);
        do_write(32'h20, 32'h1234, 2, 0);
        do_read(32'h20, rd, cyc);
        chk("ro_alias_id", rd, ID_VAL);
        do_read(32'h0, rd, cyc);
        chk("ro_id", rd, ID_VAL);

        // Randomized traffic against the model
        irq_src = 4'($urandom);
        @(negedge clk);
        m_pend = irq_src;
        irq_src = 4'h0;
        for (int it = 0; it < 40; it++) begin
            gpio_in = 8'($urandom);
            idx = $urandom_range(0, 7);
            a = ($urandom & 32'hFFFF_FFE3) | (32'(idx) << 2);
            d = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                do_write(a, d, $urandom_range(0, 3), $urandom_range(0, 3));
                case (idx)
                    1: m_scratch = d;
                    4: m_gpio = d[7:0];
                    6: m_pend = m_pend & ~d[3:0];
                    7: m_mask = d[3:0];
                    default: ;
                endcase
            end else begin
                do_read(a, rd, cyc);
                case (idx)
                    0: exp = ID_VAL;
                    1: exp = m_scratch;
                    2: exp = cyc[31:0];
                    3: exp = m_shadow;
                    4: exp = {24'd0, m_gpio};
                    5: exp = {24'd0, gpio_in};
                    6: exp = {28'd0, m_pend};
                    default: exp = {28'd0, m_mask};
                endcase
                if (idx == 2) m_shadow = cyc[63:32];
                chk($sformatf("rand_read_idx%0d", idx), rd, exp);
            end
            chk("rand_gpio_out", gpio_out, m_gpio);
            chk("rand_irq", irq, (m_pend & m_mask) != 4'h0);
        end

        // Coherent counter reads across the low-word wrap
        srst = 1;
        repeat (2) @(negedge clk);
        srst = 0;
        model_reset();
        @(negedge clk);
        for (int it = 0; it < 10; it++) begin
            repeat ($urandom_range(0, 6)) @(negedge clk);
            do_read(32'h8, rd, cyc);
            chk("cyc_lo", rd, cyc[31:0]);
            m_shadow = cyc[63:32];
            repeat ($urandom_range(0, 6)) @(negedge clk);
            do_read(32'hC, rd, cyc);
            chk("cyc_hi_shadow", rd, m_shadow);
        end
        chk("cyc_hi_after_wrap", rd, 32'h2);

        // Reset while B and R are pending drops both
        mmio_awvalid = 1; mmio_awaddr = 32'h4; mmio_wvalid = 1; mmio_wdata = 32'hDEAD_BEEF;
        mmio_arvalid = 1; mmio_araddr = 32'h0;
        @(negedge clk);
        mmio_awvalid = 0; mmio_wvalid = 0; mmio_arvalid = 0;
        chk("mid_bvalid", mmio_bvalid, 1);
        chk("mid_rvalid", mmio_rvalid, 1);
        srst = 1;
        @(negedge clk);
        chk("mid_rst_bvalid", mmio_bvalid, 0);
        chk("mid_rst_rvalid", mmio_rvalid, 0);
        chk("mid_rst_awready", mmio_awready, 0);
        srst = 0;
        model_reset();
        @(negedge clk);
        chk("mid_post_bvalid", mmio_bvalid, 0);
        chk("mid_post_rvalid", mmio_rvalid, 0);
        chk("mid_post_awready", mmio_awready, 1);
        do_read(32'h4, rd, cyc);
        chk("mid_scratch_reset", rd, m_scratch);
        do_read(32'hC, rd, cyc);
        chk("mid_shadow_reset", rd, m_shadow);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
